// File: rtl/mux42_pkg.sv
// Shared types for the mux42 scanner: channel count, channel index width,
// FSM state encoding and a highest-enabled-channel helper.
package mux42_pkg;

    localparam int N_CH = 4;
    localparam int CH_W = 2;

    typedef logic [CH_W-1:0] ch_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DWELL   = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    function automatic ch_t highest_ch(input logic [N_CH-1:0] mask);
        ch_t h = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (mask[i]) h = ch_t'(i);
        end
        return h;
    endfunction

endpackage

// File: rtl/mux42_rr_next.sv
// Round-robin search: first channel set in mask at or after start, wrapping 3->0.
module mux42_rr_next
    import mux42_pkg::*;
(
    input  ch_t             start,
    input  logic [N_CH-1:0] mask,
    output ch_t             idx,
    output logic            found
);

    // Walk offsets from farthest to nearest so the nearest hit wins.
    always_comb begin
        idx   = start;
        found = 1'b0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask[start + ch_t'(i)]) begin
                idx   = start + ch_t'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux42_scan.sv
// Scans an external 4:1 mux: dwells on each enabled channel, then captures
// mux_f into that channel's slot of sample. All outputs are registered.
module mux42_scan
    import mux42_pkg::*;
#(
    parameter int DWELL  = 4,
    parameter int DATA_W = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [N_CH-1:0]        ch_mask,
    input  logic [DATA_W-1:0]      mux_f,
    output logic [CH_W-1:0]        sel,
    output logic [N_CH*DATA_W-1:0] sample,
    output logic                   sample_vld,
    output logic                   sweep_done,
    output logic                   busy
);

    localparam logic [7:0] CNT_LOAD = 8'(DWELL - 1);

    state_e                  state_q, state_d;
    ch_t                     sel_q, sel_d;
    ch_t                     ptr_q, ptr_d;
    logic [7:0]              cnt_q, cnt_d;
    logic [N_CH*DATA_W-1:0]  sample_q, sample_d;
    logic                    vld_q, vld_d;
    logic                    done_q, done_d;
    logic                    busy_q, busy_d;

    ch_t  rr_start;
    ch_t  rr_idx;
    logic rr_found;

    // IDLE resumes at ptr; DWELL aborts and CAPTURE advance search past sel.
    assign rr_start = (state_q == ST_IDLE) ? ptr_q : sel_q + ch_t'(1);

    mux42_rr_next u_rr_next (
        .start (rr_start),
        .mask  (ch_mask),
        .idx   (rr_idx),
        .found (rr_found)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // NOTE: every variable gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (en && rr_found) state_d = ST_DWELL;
            end
            ST_DWELL: begin
                if (!en)                  state_d = ST_IDLE;
                else if (!ch_mask[sel_q]) state_d = rr_found ? ST_DWELL : ST_IDLE;
                else if (cnt_q == '0)     state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_d = (en && rr_found) ? ST_DWELL : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        sel_d    = sel_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        vld_d    = 1'b0;
        done_d   = 1'b0;
        busy_d   = (state_d != ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (state_d == ST_DWELL) begin
                    sel_d = rr_idx;
                    cnt_d = CNT_LOAD;
                end
            end
            ST_DWELL: begin
                if (state_d == ST_DWELL) begin
                    if (!ch_mask[sel_q]) begin
                        sel_d = rr_idx;
                        cnt_d = CNT_LOAD;
                    end else begin
                        cnt_d = cnt_q - 8'd1;
                    end
                end
            end
            ST_CAPTURE: begin
                sample_d[int'(sel_q)*DATA_W +: DATA_W] = mux_f;
                vld_d  = 1'b1;
                done_d = ch_mask[sel_q] && (sel_q == highest_ch(ch_mask));
                ptr_d  = sel_q + ch_t'(1);
                if (state_d == ST_DWELL) begin
                    sel_d = rr_idx;
                    cnt_d = CNT_LOAD;
                end
            end
            default: ;
        endcase
    end

    // NOTE: the sample register is plain flops, so it is reset like any other state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sel_q    <= '0;
            ptr_q    <= '0;
            cnt_q    <= CNT_LOAD;
            sample_q <= '0;
            vld_q    <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            sel_q    <= sel_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            vld_q    <= vld_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign sel        = sel_q;
    assign sample     = sample_q;
    assign sample_vld = vld_q;
    assign sweep_done = done_q;
    assign busy       = busy_q;

endmodule
